// File: rtl/flow_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flow_control_pkg
// Description : Shared sizing helpers for the sum/total valid-ready stages.
// Revision    : 1.0 - initial release
// ============================================================================
package flow_control_pkg;

    // Width that holds group_size maximum (width+1)-bit sums without overflow.
    function automatic int total_width(input int width, input int group_size);
        return width + 1 + $clog2(group_size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sum_group_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sum_group_accumulator
// Description : Adds every GROUP_SIZE accepted sums into one registered total.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_group_accumulator
    import flow_control_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GROUP_SIZE = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       sum_vld,
    output logic                                       sum_rdy,
    input  logic [WIDTH:0]                             sum_data,
    output logic                                       total_vld,
    input  logic                                       total_rdy,
    output logic [total_width(WIDTH, GROUP_SIZE)-1:0]  total_data
);

    localparam int            TW   = total_width(WIDTH, GROUP_SIZE);
    localparam int            CW   = $clog2(GROUP_SIZE);
    localparam logic [CW-1:0] LAST = CW'(GROUP_SIZE - 1);

    logic [TW-1:0] acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic          total_vld_q, total_vld_d;
    logic [TW-1:0] total_data_q, total_data_d;

    logic          sum_fire;
    logic          last_item;
    logic [TW-1:0] acc_sum;

    // A slot opens whenever the output register is empty or draining this cycle.
    assign sum_rdy   = ~total_vld_q | total_rdy;
    assign sum_fire  = sum_vld & sum_rdy;
    assign last_item = (count_q == LAST);
    assign acc_sum   = acc_q + TW'(sum_data);

    always_comb begin
        acc_d        = acc_q;
        count_d      = count_q;
        total_vld_d  = total_vld_q;
        total_data_d = total_data_q;

        if (sum_fire) begin
            if (last_item) begin
                acc_d   = '0;
                count_d = '0;
            end else begin
                acc_d   = acc_sum;
                count_d = count_q + CW'(1);
            end
        end

        // Loading a new total takes priority so a drain+load cycle has no bubble.
        if (sum_fire && last_item) begin
            total_vld_d  = 1'b1;
            total_data_d = acc_sum;
        end else if (total_vld_q && total_rdy) begin
            total_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            count_q <= '0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_vld_q  <= 1'b0;
            total_data_q <= '0;
        end else begin
            total_vld_q  <= total_vld_d;
            total_data_q <= total_data_d;
        end
    end

    assign total_vld  = total_vld_q;
    assign total_data = total_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sum_group_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_group_accumulator
// Description : Scoreboard bench for sum_group_accumulator (WIDTH=4, GROUP=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_group_accumulator;
    import flow_control_pkg::*;

    localparam int WIDTH = 4;
    localparam int GROUP = 4;
    localparam int TW    = total_width(WIDTH, GROUP);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sum_vld = 1'b0;
    logic          sum_rdy;
    logic [WIDTH:0] sum_data = '0;
    logic          total_vld;
    logic          total_rdy = 1'b1;
    logic [TW-1:0] total_data;

    int checks = 0;
    int errors = 0;

    logic [TW-1:0] exp_q[$];
    bit            use_model = 1'b0;
    bit            rand_rdy  = 1'b0;
    int            model_cnt = 0;
    logic [TW-1:0] model_acc = '0;
    int            accepted  = 0;
    int            totals    = 0;

    sum_group_accumulator #(.WIDTH(WIDTH), .GROUP_SIZE(GROUP)) dut (
        .clk        (clk),
        .rst        (rst),
        .sum_vld    (sum_vld),
        .sum_rdy    (sum_rdy),
        .sum_data   (sum_data),
        .total_vld  (total_vld),
        .total_rdy  (total_rdy),
        .total_data (total_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Downstream ready randomiser for the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) total_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the expected total on every output handshake and checks hold while stalled.
    initial begin
        logic          stalled = 1'b0;
        logic [TW-1:0] held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_vld", 32'(total_vld), 32'd1);
                    check("hold_data", 32'(total_data), 32'(held));
                end
                if (total_vld && total_rdy) begin
                    totals++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_total", 32'(total_data), 32'hffff_ffff);
                    end else begin
                        check("total", 32'(total_data), 32'(exp_q.pop_front()));
                    end
                end
                stalled = total_vld && !total_rdy;
                held    = total_data;
            end
        end
    end

    // Presents one sum, holds it until accepted; returns at posedge+1 after the handshake.
    task automatic send(input logic [WIDTH:0] d);
        int n = 0;
        sum_vld  = 1'b1;
        sum_data = d;
        @(negedge clk);
        while (!sum_rdy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!sum_rdy) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            accepted++;
            if (use_model) begin
                model_acc = model_acc + TW'(d);
                model_cnt++;
                if (model_cnt == GROUP) begin
                    exp_q.push_back(model_acc);
                    model_acc = '0;
                    model_cnt = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sum_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Reset state and idle
        @(negedge clk);
        check("rst_total_vld", 32'(total_vld), 32'd0);
        check("rst_total_data", 32'(total_data), 32'd0);
        check("rst_sum_rdy", 32'(sum_rdy), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        idle(2);
        check("idle_sum_rdy", 32'(sum_rdy), 32'd1);

        // 2. Back-to-back 1..8, total visible right after the 4th/8th handshake
        exp_q.push_back(TW'(8'h0a));
        exp_q.push_back(TW'(8'h1a));
        for (int i = 1; i <= 4; i++) send(5'(i));
        check("lat_vld_1", 32'(total_vld), 32'd1);
        check("lat_data_1", 32'(total_data), 32'h0a);
        for (int i = 5; i <= 8; i++) send(5'(i));
        check("lat_vld_2", 32'(total_vld), 32'd1);
        check("lat_data_2", 32'(total_data), 32'h1a);
        idle(3);

        // 3. Max inputs
        exp_q.push_back(TW'(8'h7c));
        for (int i = 0; i < 4; i++) send(5'd31);
        idle(3);

        // 4. Backpressure
        total_rdy = 1'b0;
        exp_q.push_back(TW'(8'h0a));
        for (int i = 1; i <= 4; i++) send(5'(i));
        idle(3);
        @(negedge clk);
        check("bp_total_vld", 32'(total_vld), 32'd1);
        check("bp_total_data", 32'(total_data), 32'h0a);
        check("bp_sum_rdy", 32'(sum_rdy), 32'd0);
        @(posedge clk);
        #1;
        total_rdy = 1'b1;
        #1;
        check("bp_release_sum_rdy", 32'(sum_rdy), 32'd1);
        idle(3);

        // 5. Reset mid-group discards the partial 9+9
        send(5'd9);
        send(5'd9);
        sum_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_total_vld", 32'(total_vld), 32'd0);
        check("midrst_sum_rdy", 32'(sum_rdy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(TW'(8'h04));
        for (int i = 0; i < 4; i++) send(5'd1);
        idle(3);
        check("directed_drained", 32'(exp_q.size()), 32'd0);

        // 6. Random valid gaps and downstream ready, 100 groups
        accepted  = 0;
        totals    = 0;
        model_acc = '0;
        model_cnt = 0;
        use_model = 1'b1;
        rand_rdy  = 1'b1;
        for (int i = 0; i < 100 * GROUP; i++) begin
            send(5'($urandom_range(0, 31)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        sum_vld  = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        total_rdy = 1'b1;
        idle(10);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rand_totals", 32'(totals), 32'd100);
        check("rand_accept_ratio", 32'(accepted), 32'(GROUP * totals));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
